mem_copy_ctrl: RTL
==================

// Module: mem_copy_ctrl
// PURPOSE
//  Block-copy sequencer for the two-memory datapath: source ROM (dmem_init, async read) feeding
//  destination RAM (mem32, async read / sync write) through a shared 32-bit write-data wire.
//  Copies len words from src_base to dst_base, one word per clock; optional readback verify.
//  Sits between the top-level control (start/abort) and the memory address/write-enable pins.
// PARAMETERS
//  ADDR_W  5   word-address width of both memories (depth 2**ADDR_W = 32)
//  DATA_W  32  memory word width (used only by the verify comparator)
// PORTS
//  clk       in   1        single clock, rising edge
//  rst_n     in   1        asynchronous active-low reset
//  start     in   1        begin copy; sampled only in IDLE
//  abort     in   1        stop current operation; return to IDLE
//  src_base  in   ADDR_W   first source word address, captured on accepted start
//  dst_base  in   ADDR_W   first destination word address, captured on accepted start
//  len       in   ADDR_W+1 word count 0..32, captured on accepted start
//  src_rd    in   DATA_W   source memory read data (verify compare only)
//  dst_rd    in   DATA_W   destination memory read data (verify compare only)
//  src_adr   out  ADDR_W   source memory address
//  dst_adr   out  ADDR_W   destination memory address
//  dst_we    out  1        destination memory write enable
//  busy      out  1        high in any state other than IDLE
//  done      out  1        one-cycle pulse at end of copy (and verify, if built)
//  err       out  1        verify mismatch flag, sticky until next accepted start
//  err_idx   out  ADDR_W   word offset of first mismatch
//  count     out  ADDR_W+1 words processed in current phase
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; captured bases/len = 0.
//  - FSM: IDLE -> COPY on start (len!=0); IDLE -> DONE on start with len==0 (no writes);
//    COPY -> VERIFY|DONE after len writes; VERIFY -> DONE after len compares; DONE -> IDLE.
//  - Outputs are registered state decodes. dst_we = (state==COPY) && !abort.
//  - src_adr = src_base_q + cnt and dst_adr = dst_base_q + cnt, both modulo 2**ADDR_W (wrap 31->0).
//    Addresses are 0 in IDLE/DONE.
//  - COPY: word k is written on the k-th rising edge after start is accepted (k=1..len).
//    done pulses in the cycle after the last write; start-to-done latency = len+1 cycles.
//  - start while busy: ignored. No parameter changes take effect mid-operation.
//  - abort (any non-IDLE state): dst_we forced 0 in the same cycle; IDLE on next edge; no done;
//    err keeps its value. abort and start together in IDLE: abort wins, start dropped.
//  - rst_n asserted mid-operation: immediate IDLE; partial writes in the RAM remain.
//  - count resets to 0 on entry to COPY and to VERIFY; saturates at len.
// CONFIGURATION
//  - MEM_COPY_VERIFY_EN defined: after COPY, VERIFY runs len cycles with dst_we=0 and the same
//    address walk. Each cycle compares src_rd against dst_rd. The first mismatch sets err and
//    latches err_idx=cnt. done pulses after VERIFY; latency = 2*len+1.
//  - MEM_COPY_VERIFY_EN undefined: VERIFY state absent; err=0 and err_idx=0 constantly;
//    src_rd/dst_rd unused.
// STRUCTURE
//  - mem_ctrl_pkg: ADDR_W/DATA_W defaults, typedef enum logic [1:0] {IDLE,COPY,VERIFY,DONE} copy_state_t,
//    typedef logic [ADDR_W-1:0] word_adr_t.
//  - One natural sub-module: mem_addr_gen (base + counter, modulo wrap, clear/enable, terminal-count
//    flag), instantiated once and shared by COPY and VERIFY.
// TESTING
//  1 src_base=0,dst_base=4,len=8, start 1 cycle -> dst_we high 8 cycles, dst_adr 4..11,
//    done at cycle 9, RAM[4..11]==ROM[0..7].
//  2 src_base=28,dst_base=30,len=6 -> src_adr 28..31,0,1; dst_adr 30,31,0..3; wrap correct.
//  3 len=0 -> no dst_we, done 1 cycle after start, busy high exactly 1 cycle.
//  4 len=32, abort asserted at copy cycle 10 -> dst_we low that cycle, IDLE next, no done,
//    only 9 RAM words changed; rst_n pulsed mid-copy gives the same result asynchronously.
//  5 start pulsed again while busy -> ignored; count and addresses continue undisturbed.
//  6 (MEM_COPY_VERIFY_EN) len=8, bench corrupts dst_rd at offset 5 -> err=1, err_idx=5,
//    done at cycle 17; a clean rerun from a new start clears err.

Source files
------------

// File: rtl/mem_copy_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and default widths for the block-copy sequencer.
//   ADDR_W_DEF / DATA_W_DEF : default word-address / data widths
//   copy_state_t            : sequencer states
//   word_adr_t / word_cnt_t : word address and word count (count spans 0..2**ADDR_W)
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COPY   = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } copy_state_t;

  typedef logic [ADDR_W_DEF-1:0] word_adr_t;
  typedef logic [ADDR_W_DEF:0]   word_cnt_t;

endpackage

// File: rtl/mem_copy_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_copy_ctrl_if
// Control and memory-pin bundle between the top-level control, the copy
// sequencer and the two memories.
//   slave  : sequencer view (takes start/abort/bases/len/read data,
//            drives addresses, write enable and status)
//   master : control / memory view (the opposite directions)
// ---------------------------------------------------------------------------
interface mem_copy_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] src_rd;
  logic [DATA_W-1:0] dst_rd;
  logic [ADDR_W-1:0] src_adr;
  logic [ADDR_W-1:0] dst_adr;
  logic              dst_we;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_idx;
  logic [ADDR_W:0]   count;

  modport slave (
    input  start, abort, src_base, dst_base, len, src_rd, dst_rd,
    output src_adr, dst_adr, dst_we, busy, done, err, err_idx, count
  );

  modport master (
    output start, abort, src_base, dst_base, len, src_rd, dst_rd,
    input  src_adr, dst_adr, dst_we, busy, done, err, err_idx, count
  );

endinterface

// File: rtl/mem_copy_ctrl_addr_gen.sv
// ---------------------------------------------------------------------------
// mem_addr_gen
// Word counter plus two base-relative address outputs, shared by the copy
// and verify walks.
//   clk, rst_n              : clock, async active-low reset
//   clr_i                   : restart the walk at offset 0 (wins over en_i)
//   en_i                    : advance one word; the counter saturates at len_i
//   src_base_i, dst_base_i  : captured base addresses
//   len_i                   : captured word count
//   src_adr_o, dst_adr_o    : base + offset, wrapping modulo 2**ADDR_W
//   cnt_o                   : current word offset
//   last_o                  : this cycle handles the final word of the walk
// ---------------------------------------------------------------------------
module mem_addr_gen #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic [ADDR_W:0]   len_i,
  output logic [ADDR_W-1:0] src_adr_o,
  output logic [ADDR_W-1:0] dst_adr_o,
  output logic [ADDR_W:0]   cnt_o,
  output logic              last_o
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic [ADDR_W:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (en_i && (cnt_q != len_i)) cnt_d = cnt_q + CNT_ONE;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Dropping the count MSB makes the sum wrap naturally at 2**ADDR_W.
  assign src_adr_o = src_base_i + cnt_q[ADDR_W-1:0];
  assign dst_adr_o = dst_base_i + cnt_q[ADDR_W-1:0];
  assign cnt_o     = cnt_q;
  assign last_o    = ((cnt_q + CNT_ONE) == len_i);

endmodule

// File: rtl/mem_copy_ctrl.sv
// ---------------------------------------------------------------------------
// mem_copy_ctrl
// Block-copy sequencer: copies len words from the source ROM at src_base to
// the destination RAM at dst_base, one word per clock, driving the memory
// address and write-enable pins. Optional readback verify.
//   clk, rst_n : clock, async active-low reset
//   bus        : mem_copy_ctrl_if.slave
//                in : start, abort, src_base, dst_base, len, src_rd, dst_rd
//                out: src_adr, dst_adr, dst_we, busy, done, err, err_idx, count
// Build option: define MEM_COPY_VERIFY_EN to add a VERIFY pass after COPY
// that compares src_rd with dst_rd over the same address walk; otherwise
// err/err_idx are tied to 0 and the read-data inputs are ignored.
// ---------------------------------------------------------------------------
module mem_copy_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_copy_ctrl_if.slave bus
);

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] src_base_q, dst_base_q;
  logic [ADDR_W:0]   len_q;

  logic              accept;   // start taken this cycle: capture parameters
  logic              gen_clr, gen_en, gen_last;
  logic [ADDR_W-1:0] gen_src_adr, gen_dst_adr;
  logic [ADDR_W:0]   gen_cnt;

  mem_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (gen_clr),
    .en_i       (gen_en),
    .src_base_i (src_base_q),
    .dst_base_i (dst_base_q),
    .len_i      (len_q),
    .src_adr_o  (gen_src_adr),
    .dst_adr_o  (gen_dst_adr),
    .cnt_o      (gen_cnt),
    .last_o     (gen_last)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    gen_clr = 1'b0;
    gen_en  = 1'b0;
    case (state_q)
      IDLE: begin
        // abort outranks a simultaneous start
        if (bus.start && !bus.abort) begin
          accept  = 1'b1;
          gen_clr = 1'b1;
          state_d = (bus.len == '0) ? DONE : COPY;
        end
      end
      COPY: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          gen_en = 1'b1;
          if (gen_last) begin
`ifdef MEM_COPY_VERIFY_EN
            gen_clr = 1'b1;
            state_d = VERIFY;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef MEM_COPY_VERIFY_EN
      VERIFY: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          gen_en = 1'b1;
          if (gen_last) state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      src_base_q <= '0;
      dst_base_q <= '0;
      len_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_base_q <= bus.src_base;
        dst_base_q <= bus.dst_base;
        len_q      <= bus.len;
      end
    end
  end

`ifdef MEM_COPY_VERIFY_EN
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_idx_q, err_idx_d;

  // Only the first mismatch since the last accepted start is recorded.
  always_comb begin
    err_d     = err_q;
    err_idx_d = err_idx_q;
    if (accept) begin
      err_d     = 1'b0;
      err_idx_d = '0;
    end else if ((state_q == VERIFY) && !bus.abort && !err_q &&
                 (bus.src_rd != bus.dst_rd)) begin
      err_d     = 1'b1;
      err_idx_d = gen_cnt[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign bus.err     = err_q;
  assign bus.err_idx = err_idx_q;
`else
  logic unused_rd;
  assign unused_rd   = ^{bus.src_rd, bus.dst_rd};
  assign bus.err     = 1'b0;
  assign bus.err_idx = '0;
`endif

  logic walking;
  assign walking = (state_q == COPY) || (state_q == VERIFY);

  // abort gates the write in the same cycle it is raised
  assign bus.dst_we  = (state_q == COPY) && !bus.abort;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.src_adr = walking ? gen_src_adr : '0;
  assign bus.dst_adr = walking ? gen_dst_adr : '0;
  assign bus.count   = gen_cnt;

endmodule
